// File: rtl/mem_requester.sv
// Core-side memory initiator: encodes one read/write request as a link message
// and decodes the 16-byte read response; stray responses are popped and counted.
module mem_requester #(
  parameter int unsigned MSG_BITS       = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_wmask,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [127:0]        rdata,
  output logic [7:0]          stray_cnt,
  output logic                tx_flag,
  output logic [4:0]          tx_length,
  output logic [MSG_BITS-1:0] tx_data,
  input  logic                tx_ready,
  input  logic                rx_avail,
  input  logic [4:0]          rx_length,
  input  logic [MSG_BITS-1:0] rx_data,
  output logic                rx_pop
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] FINISH    = 2'd3;

  localparam int unsigned    CNT_W   = 32;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic           TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]          state, state_d;
  logic                wr_q, wr_d;
  logic                to_q, to_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                busy_d, done_d, err_d, tx_flag_d, rx_pop_d;
  logic [4:0]          tx_length_d;
  logic [MSG_BITS-1:0] tx_data_d;
  logic [127:0]        rdata_d;
  logic [7:0]          stray_d;
  logic                stray_inc;
  logic                rx_ok;
  logic                rx_good;
  logic                rx_unused;

  // rx_avail is still the already-popped message in the cycle rx_pop is high
  assign rx_ok     = rx_avail & ~rx_pop;
  assign rx_good   = (rx_length == 5'd16);
  assign rx_unused = ^rx_data[MSG_BITS-1:128];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      to_q      <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tx_flag   <= 1'b0;
      rx_pop    <= 1'b0;
      tx_length <= 5'd0;
      tx_data   <= '0;
      rdata     <= '0;
      stray_cnt <= 8'd0;
    end else begin
      state     <= state_d;
      wr_q      <= wr_d;
      to_q      <= to_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      tx_flag   <= tx_flag_d;
      rx_pop    <= rx_pop_d;
      tx_length <= tx_length_d;
      tx_data   <= tx_data_d;
      rdata     <= rdata_d;
      stray_cnt <= stray_d;
    end
  end

  always_comb begin
    state_d     = state;
    wr_d        = wr_q;
    to_d        = to_q;
    cnt_d       = cnt;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tx_flag_d   = 1'b0;
    rx_pop_d    = 1'b0;
    tx_length_d = tx_length;
    tx_data_d   = tx_data;
    rdata_d     = rdata;
    stray_inc   = 1'b0;

    // outside WAIT_RESP every response is unsolicited
    if (rx_ok && (state != WAIT_RESP)) begin
      rx_pop_d  = 1'b1;
      stray_inc = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req_valid) begin
          busy_d    = 1'b1;
          wr_d      = req_write;
          to_d      = 1'b0;
          tx_data_d = '0;
          if (req_write) begin
            tx_length_d       = 5'd9;
            tx_data_d[31:0]   = req_wdata;
            tx_data_d[63:32]  = req_addr;
            tx_data_d[71:64]  = {4'b0000, req_wmask};
          end else begin
            tx_length_d       = 5'd5;
            tx_data_d[31:0]   = req_addr;
          end
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_flag_d = 1'b1;
          cnt_d     = '0;
          state_d   = wr_q ? FINISH : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rx_ok) begin
          rx_pop_d = 1'b1;
          if (rx_good) begin
            rdata_d = rx_data[127:0];
            state_d = FINISH;
          end else begin
            stray_inc = 1'b1;
          end
        end
        // a good response in the expiry cycle wins over the timeout
        if (!(rx_ok && rx_good)) begin
          if (TO_EN && (cnt == TO_LAST)) begin
            to_d    = 1'b1;
            state_d = FINISH;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        err_d   = to_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    stray_d = (stray_inc && (stray_cnt != 8'hFF)) ? stray_cnt + 8'd1 : stray_cnt;
  end

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: vector table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_mem_requester;

  localparam int TO = 50;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_valid, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_wmask;
  logic         busy, done, err;
  logic [127:0] rdata;
  logic [7:0]   stray_cnt;
  logic         tx_flag;
  logic [4:0]   tx_length;
  logic [255:0] tx_data;
  logic         tx_ready, rx_avail;
  logic [4:0]   rx_length;
  logic [255:0] rx_data;
  logic         rx_pop;

  int n_cmp = 0;
  int n_fail = 0;
  logic [127:0] m_rdata;
  int           m_stray;

  mem_requester #(.MSG_BITS(256), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .stray_cnt(stray_cnt),
    .tx_flag(tx_flag), .tx_length(tx_length), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_avail(rx_avail), .rx_length(rx_length), .rx_data(rx_data), .rx_pop(rx_pop)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           flag_k;
    int           flag_cnt;
    logic [4:0]   len;
    logic [255:0] data;
    int           done_c;
    int           done_cnt;
    logic         err;
    int           pops;
    logic         stable;
    logic         busy_ok;
    logic         busy_at_done;
    logic         timeout;
  } obs_t;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   mask;
    logic [127:0] resp;
    logic [4:0]   exp_len;
    logic [71:0]  exp_msg;
    logic [127:0] exp_rdata;
    int           exp_done_c;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, play the link side, and record what the DUT did.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int rdy_delay, input int junk_j,
                     input int good_j, input logic [127:0] resp, output obs_t o);
    int k;
    int c;
    int last_j;
    logic [255:0] d0;
    logic [4:0]   l0;
    bit fin;
    o = '{default: 0};
    o.flag_k = -1; o.done_c = -1; o.stable = 1'b1; o.busy_ok = 1'b1;
    last_j = (junk_j > good_j) ? junk_j : good_j;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    tx_ready = (rdy_delay == 0);
    k = 0; fin = 0; d0 = '0; l0 = '0;
    while (!fin && k < 400) begin
      tick();
      k++;
      if (k == 1) begin
        req_valid = 1'b0; d0 = tx_data; l0 = tx_length;
        req_addr = $urandom; req_wdata = $urandom; req_write = ~wr;
      end
      if (k >= rdy_delay) tx_ready = 1'b1;
      if (o.flag_k < 0 && (tx_data !== d0 || tx_length !== l0)) o.stable = 1'b0;
      if (tx_flag) begin
        o.flag_cnt++;
        if (o.flag_k < 0) begin o.flag_k = k; o.len = tx_length; o.data = tx_data; end
      end
      if (!done && o.done_cnt == 0 && !busy) o.busy_ok = 1'b0;
      if (rx_pop) begin o.pops++; rx_avail = 1'b0; end
      if (done) begin
        o.done_cnt++;
        if (o.done_c < 0) begin
          o.done_c = (o.flag_k < 0) ? -2 : k - o.flag_k;
          o.err = err; o.busy_at_done = busy;
        end
      end
      if (o.flag_k >= 0) begin
        c = k - o.flag_k;
        if (c == junk_j) begin
          rx_avail = 1'b1; rx_length = 5'd4;
          rx_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        if (c == good_j) begin
          rx_avail = 1'b1; rx_length = 5'd16;
          rx_data = {$urandom, $urandom, $urandom, $urandom, resp};
        end
        if (o.done_c >= 0 && k >= o.flag_k + o.done_c + 2 && c > last_j && !rx_avail) fin = 1;
      end
    end
    o.timeout = !fin;
  endtask

  task automatic expect_txn(input string tag, input obs_t o, input int e_flag_k,
                            input logic [4:0] e_len, input logic [255:0] e_data,
                            input int e_done_c, input logic e_err, input int e_pops);
    check($sformatf("%s finished", tag), 256'(o.timeout), 256'(0));
    check($sformatf("%s tx_flag count", tag), 256'(o.flag_cnt), 256'(1));
    check($sformatf("%s tx_flag cycle", tag), 256'(o.flag_k), 256'(e_flag_k));
    check($sformatf("%s tx_length", tag), 256'(o.len), 256'(e_len));
    check($sformatf("%s tx_data", tag), o.data, e_data);
    check($sformatf("%s tx stable", tag), 256'(o.stable), 256'(1));
    check($sformatf("%s busy held", tag), 256'(o.busy_ok), 256'(1));
    check($sformatf("%s done count", tag), 256'(o.done_cnt), 256'(1));
    check($sformatf("%s done latency", tag), 256'(o.done_c), 256'(e_done_c));
    check($sformatf("%s err", tag), 256'(o.err), 256'(e_err));
    check($sformatf("%s busy at done", tag), 256'(o.busy_at_done), 256'(0));
    check($sformatf("%s pops", tag), 256'(o.pops), 256'(e_pops));
    check($sformatf("%s rdata", tag), 256'(rdata), 256'(m_rdata));
    check($sformatf("%s stray_cnt", tag), 256'(stray_cnt), 256'(m_stray));
  endtask

  // Reference model: encoding by arithmetic, read outcome from response timing rules.
  task automatic model_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask, input int rdy_delay,
                           input int junk_j, input int good_j, input logic [127:0] resp);
    obs_t o;
    logic [255:0] e_data;
    int e_done_c;
    int e_pops;
    logic e_err;
    bit accepted;
    txn(wr, addr, wdata, mask, rdy_delay, junk_j, good_j, resp, o);
    if (wr) e_data = 256'(wdata) + (256'(addr) << 32) + (256'(mask) << 64);
    else    e_data = 256'(addr);
    accepted = !wr && good_j >= 0 && good_j < TO;
    e_err    = !wr && !accepted;
    e_done_c = wr ? 1 : (accepted ? good_j + 2 : TO + 1);
    e_pops   = wr ? 0 : int'(junk_j >= 0) + int'(good_j >= 0);
    if (accepted) m_rdata = resp;
    if (!wr) m_stray = m_stray + int'(junk_j >= 0) + int'(good_j >= 0 && !accepted);
    if (m_stray > 255) m_stray = 255;
    expect_txn(tag, o, ((rdy_delay > 1) ? rdy_delay : 1) + 1, wr ? 5'd9 : 5'd5, e_data,
               e_done_c, e_err, e_pops);
  endtask

  task automatic idle_reply(input logic [4:0] len);
    int w;
    rx_avail = 1'b1; rx_length = len;
    rx_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w = 0;
    while (!rx_pop && w < 5) begin tick(); w++; end
    if (!rx_pop) begin
      n_cmp++; n_fail++;
      $display("FAIL idle pop: no rx_pop within %0d cycles", w);
    end
    rx_avail = 1'b0;
    m_stray = (m_stray < 255) ? m_stray + 1 : 255;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s busy", tag), 256'(busy), 256'(0));
    check($sformatf("%s done", tag), 256'(done), 256'(0));
    check($sformatf("%s err", tag), 256'(err), 256'(0));
    check($sformatf("%s tx_flag", tag), 256'(tx_flag), 256'(0));
    check($sformatf("%s rx_pop", tag), 256'(rx_pop), 256'(0));
    check($sformatf("%s tx_length", tag), 256'(tx_length), 256'(0));
    check($sformatf("%s tx_data", tag), tx_data, 256'(0));
    check($sformatf("%s rdata", tag), 256'(rdata), 256'(0));
    check($sformatf("%s stray_cnt", tag), 256'(stray_cnt), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    obs_t o;
    int w;
    logic [127:0] r0;
    logic [127:0] r1;
    r0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    r1 = 128'hA5A5_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
    vt[0] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, r0, 5'd5, 72'h00_00000000_00000010, r0, 2};
    vt[1] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'h5, r1, 5'd9, 72'h05_00000104_DEADBEEF, r0, 1};
    vt[2] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, r1, 5'd9, 72'h0F_FFFFFFFC_12345678, r0, 1};
    vt[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'h0, r1, 5'd5, 72'h00_00000000_FFFFFFFF, r1, 2};
    vt[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'h0, r0, 5'd9, 72'h00_00000000_00000000, r1, 1};

    RST = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    tx_ready = 1'b1; rx_avail = 0; rx_length = 0; rx_data = '0;
    m_rdata = '0; m_stray = 0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check_reset_values("reset");

    for (int i = 0; i < 5; i++) begin
      txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].mask, 0, -1, vt[i].wr ? -1 : 0, vt[i].resp, o);
      m_rdata = vt[i].exp_rdata;
      expect_txn($sformatf("vec%0d", i), o, 2, vt[i].exp_len, 256'(vt[i].exp_msg),
                 vt[i].exp_done_c, 1'b0, vt[i].wr ? 0 : 1);
    end

    model_txn("backpressure", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 21, -1, 3, r1);
    model_txn("timeout late reply", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, -1, 60, r0);
    model_txn("junk then good", 1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 3, 10, r0);
    model_txn("reply at expiry", 1'b0, 32'h0000_0034, 32'h0, 4'h0, 0, -1, TO - 1, r1);
    model_txn("reply after expiry", 1'b0, 32'h0000_0038, 32'h0, 4'h0, 0, -1, TO, r0);
    model_txn("no reply", 1'b0, 32'h0000_003C, 32'h0, 4'h0, 3, -1, -1, r0);

    // reset while a read waits for its response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
    tick();
    req_valid = 1'b0;
    w = 0;
    while (!tx_flag && w < 10) begin tick(); w++; end
    check("reset-seq tx_flag seen", 256'(tx_flag), 256'(1));
    repeat (3) tick();
    #3;
    RST = 1'b1;
    #1;
    check_reset_values("mid-wait reset");
    tick();
    tick();
    RST = 1'b0;
    m_rdata = '0; m_stray = 0;
    tick();
    idle_reply(5'd16);
    check("in-flight reply stray", 256'(stray_cnt), 256'(1));
    check("in-flight reply rdata", 256'(rdata), 256'(0));
    model_txn("read after reset", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, -1, 1, r1);

    for (int i = 0; i < 40; i++) begin
      logic wr;
      int jj;
      int gj;
      int rd;
      int r;
      wr = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 25) : $urandom_range(0, 5);
      jj = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 55) : -1;
      r  = $urandom_range(0, 9);
      if (r == 0)      gj = -1;
      else if (r == 1) gj = $urandom_range(TO - 5, TO + 10);
      else             gj = $urandom_range(0, 20);
      if (jj >= 0 && gj >= 0 && gj < jj + 2) gj = jj + 2;
      if (wr) begin jj = -1; gj = -1; end
      model_txn($sformatf("rand%0d", i), wr, $urandom, $urandom, 4'($urandom), rd, jj, gj,
                {$urandom, $urandom, $urandom, $urandom});
    end

    for (int i = 0; i < 260; i++) idle_reply(5'($urandom_range(0, 31)));
    check("stray saturation", 256'(stray_cnt), 256'(m_stray));
    check("stray saturated at 255", 256'(stray_cnt), 256'(255));
    check("busy after strays", 256'(busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- CPU-side initiator for the UART-backed simulated memory.
- Accepts one read or write request at a time from the core, encodes it as a length-tagged message for the multi-channel comm link, and decodes the 16-byte read response back to the core.
- Sits between the core's memory port and one channel of the multchan_comm link, opposite the memory responder.

Parameters:
- MSG_BITS, 256, message payload width of the comm channel.
- TIMEOUT_CYCLES, 1000000, cycles to wait in WAIT_RESP before aborting; 0 disables the timeout.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request strobe; sampled only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data; byte 0 = bits [7:0]
- req_wmask  in  4  write byte enables
- busy  out  1  high from acceptance until done/err
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, concurrent with done, on timeout
- rdata  out  128  read line; holds last successful read
- stray_cnt  out  8  saturating count of discarded responses
- tx_flag  out  1  one-cycle send pulse to the link
- tx_length  out  5  message length in bytes
- tx_data  out  MSG_BITS  message payload
- tx_ready  in  1  link can accept a message (writable)
- rx_avail  in  1  response message pending (readable)
- rx_length  in  5  response length in bytes
- rx_data  in  MSG_BITS  response payload
- rx_pop  out  1  one-cycle consume pulse

Behaviour:
- Reset (async): state IDLE; busy, done, err, tx_flag, rx_pop = 0; tx_length = 0; tx_data = 0; rdata = 0; stray_cnt = 0; timeout counter = 0.
- Reset mid-transaction aborts it with no done pulse. Any in-flight response is later counted as stray.
- Message encoding, byte 0 = bits [7:0], unused bits zero:
  - Read: length 5; [31:0] = addr; [39:32] = 8'h00.
  - Write: length 9; [31:0] = wdata; [63:32] = addr; [71:64] = {4'b0, wmask}.
- FSM states: IDLE, SEND, WAIT_RESP, FINISH.
- IDLE:
  - req_valid = 1 latches all req_* inputs, sets busy, and goes to SEND next cycle.
  - req_* is ignored while busy.
- SEND:
  - tx_length/tx_data are driven from the latched request.
  - In the first cycle with tx_ready = 1, tx_flag pulses for exactly one cycle.
  - A write goes to FINISH; a read goes to WAIT_RESP with the timeout counter cleared.
  - With tx_ready = 0, the block stays in SEND indefinitely with no timeout.
- WAIT_RESP:
  - On rx_avail = 1, rx_pop pulses for one cycle.
  - rx_length = 16: rdata <= rx_data[127:0], go to FINISH.
  - Any other length: discard, stray_cnt++, stay in WAIT_RESP.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero): go to FINISH with the error flag set; rdata is unchanged.
  - A response arriving in the same cycle as expiry is accepted, and no err is raised.
- FINISH: done = 1 (err = 1 if timed out) for one cycle, busy drops in the same cycle, return to IDLE.
- Earliest next acceptance is the cycle after FINISH.
- Latency:
  - Write: done 3 cycles after acceptance if tx_ready is held high.
  - Read: done 2 cycles after the pop cycle.
- rx_avail is ignored in the cycle after any rx_pop pulse, so a registered link deassert cannot cause a double pop.
- Responses arriving in IDLE, SEND or FINISH are popped and discarded with stray_cnt++.
- stray_cnt saturates at 255.
- tx_data/tx_length stay stable from SEND entry through the tx_flag cycle.

Test Plan:
- Read, tx_ready = 1: addr 0x00000010 → tx_length = 5, tx_data[39:0] = 40'h00_00000010. Reply 16 bytes 0x0123…CDEF → rdata = that value, done pulse, err = 0.
- Write: addr 0x00000104, wdata 0xDEADBEEF, wmask 4'b0101 → tx_length = 9, tx_data[71:0] = 72'h05_00000104_DEADBEEF, done 3 cycles after accept, no rx_pop.
- Backpressure: hold tx_ready = 0 for 20 cycles → no tx_flag and busy stays high. Release → exactly one tx_flag pulse.
- TIMEOUT_CYCLES = 50 with no response → done and err pulse together, rdata unchanged. A late 16-byte reply in IDLE → popped, stray_cnt = 1.
- Length-4 reply in WAIT_RESP → discarded, stray_cnt = 1, still busy. A following 16-byte reply completes normally.
- Assert RST during WAIT_RESP → all outputs return to reset values immediately. A new read after release completes.
